apb_buf_port: RTL and testbench
===============================

APB_BUF_PORT -- requirements
Module: apb_buf_port

Interface
REQ-001 Parameter: LATENCY, default 2, edges from buffer sample of buf_data_in to a stable buf_data_out (range 1..15).
REQ-002 Parameter: IDLE_WORD, default 32'h0000_0000, value driven on buf_data_in when not launching.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_l  in  1  reset, asynchronous, active-low.
REQ-005 psel  in  1  APB select.
REQ-006 penable  in  1  APB access phase.
REQ-007 pwrite  in  1  APB write=1, read=0.
REQ-008 paddr  in  4  APB byte address; bits [1:0] ignored.
REQ-009 pwdata  in  32  APB write data.
REQ-010 prdata  out  32  APB read data.
REQ-011 pready  out  1  APB ready, tied 1.
REQ-012 pslverr  out  1  APB error, combinational, valid in access phase.
REQ-013 buf_data_in  out  32  word to downstream circular buffer, registered.
REQ-014 buf_data_out  in  32  word returned by downstream buffer.
REQ-015 irq  out  1  interrupt, DONE & IRQ_EN.

Function
REQ-016 An APB transfer completes at the clk edge with psel=1, penable=1; zero wait states.
REQ-017 Register map: 0x0 TX (RW), 0x4 RX (RO), 0x8 STATUS, 0xC CTRL.
REQ-018 STATUS bits: [0] BUSY (RO), [1] DONE (RO), [2] OVR (W1C), [15:8] LCNT (RO); other bits read 0.
REQ-019 CTRL bits: [0] IRQ_EN (RW); other bits read 0, writes ignored.
REQ-020 FSM states IDLE, LAUNCH, WAIT; BUSY=1 in LAUNCH and WAIT.
REQ-021 IDLE + write to TX: TX<=pwdata, DONE<=0, LCNT<=LCNT+1 (8-bit wrap 255->0), next state LAUNCH.
REQ-022 LAUNCH lasts exactly one cycle with buf_data_in=TX; next state WAIT, wait counter loaded LATENCY-1.
REQ-023 WAIT lasts exactly LATENCY cycles; at its final edge RX<=buf_data_out, DONE<=1, next state IDLE.
REQ-024 With LATENCY=2, write at edge E0 gives buf_data_in=TX during E0..E1 and RX loaded at E3.
REQ-025 buf_data_in SHALL equal IDLE_WORD in every cycle outside LAUNCH.
REQ-026 Write to TX while BUSY: TX unchanged, no launch, OVR<=1, pslverr=1.
REQ-027 Read of RX clears DONE at the access edge; if DONE is set at the same edge, set wins.
REQ-028 Write 1 to STATUS[2] clears OVR; if an overrun occurs at the same edge, set wins.
REQ-029 Write to RX or to STATUS bits other than [2]: no effect, pslverr=0.
REQ-030 Access to unmapped address (none in 4-bit space after bit masking other than above) cannot occur; pslverr=0 for all reads.
REQ-031 prdata=0 whenever not in an APB read access phase.
REQ-032 TX readback returns last accepted TX value, independent of state.

Reset
REQ-033 rst_l low: state IDLE, TX=0, RX=0, DONE=0, OVR=0, LCNT=0, IRQ_EN=0, buf_data_in=IDLE_WORD, irq=0, asynchronously.
REQ-034 Reset during LAUNCH or WAIT aborts the operation; no DONE, RX remains 0 after release.
REQ-035 First launch is accepted on the first APB write access after rst_l deasserts.

Verification
REQ-036 Write TX=0xA5A5_0001 with model buffer LATENCY=2 -> buf_data_in=0xA5A5_0001 for exactly one cycle, RX=0xA5A5_0001 and DONE=1 at E3, BUSY=0 after.
REQ-037 Write TX, then second TX write one cycle later -> second write pslverr=1, OVR=1, TX holds first value, LCNT=1; write 0x4 to STATUS -> OVR=0.
REQ-038 IRQ_EN=1, launch -> irq rises with DONE; read RX -> irq=0 next cycle; read coinciding with DONE-set edge leaves DONE=1.
REQ-039 256 back-to-back launches -> LCNT=0x00 after the last, every RX matches its TX.
REQ-040 Assert rst_l low during WAIT -> buf_data_in=IDLE_WORD, STATUS=0, RX=0 immediately; no DONE after release.

Source files
------------

// File: rtl/apb_buf_port.sv
// APB slave that launches one word into a downstream circular buffer and captures
// the word returned LATENCY cycles later, with status, overrun and interrupt reporting.
module apb_buf_port #(
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [3:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [31:0] buf_data_in,
   input  logic [31:0] buf_data_out,
   output logic        irq
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int unsigned LW = 8;

   localparam logic [1:0] SEL_TX     = 2'd0;
   localparam logic [1:0] SEL_RX     = 2'd1;
   localparam logic [1:0] SEL_STATUS = 2'd2;
   localparam logic [1:0] SEL_CTRL   = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   tx_q, tx_d;
   logic [DW-1:0]   rx_q, rx_d;
   logic [DW-1:0]   bdi_q, bdi_d;
   logic [LW-1:0]   lcnt_q, lcnt_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic            done_q, done_d;
   logic            ovr_q, ovr_d;
   logic            irq_en_q, irq_en_d;
   logic            irq_q, irq_d;

   logic            wr_c, rd_c, busy_c, done_set_c, ovr_set_c;
   logic [1:0]      sel_c;
   logic [DW-1:0]   status_c;
   logic            unused_addr_c;

   assign sel_c         = paddr[3:2];
   assign unused_addr_c = ^paddr[1:0];
   assign wr_c          = psel & penable & pwrite;
   assign rd_c          = psel & penable & ~pwrite;
   assign busy_c        = (state_q != ST_IDLE);
   assign ovr_set_c     = wr_c & (sel_c == SEL_TX) & busy_c;
   assign status_c      = {16'b0, lcnt_q, 5'b0, ovr_q, done_q, busy_c};

   assign pready      = 1'b1;
   assign pslverr     = ovr_set_c;
   assign buf_data_in = bdi_q;
   assign irq         = irq_q;

   // Read mux; zero outside a read access phase.
   always_comb begin
      prdata = '0;
      if (rd_c) begin
         case (sel_c)
            SEL_TX:     prdata = tx_q;
            SEL_RX:     prdata = rx_q;
            SEL_STATUS: prdata = status_c;
            SEL_CTRL:   prdata = {31'b0, irq_en_q};
            default:    prdata = '0;
         endcase
      end
   end

   // Next-state and register updates.
   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bdi_d      = IDLE_WORD;
      lcnt_d     = lcnt_q;
      wcnt_d     = wcnt_q;
      done_d     = done_q;
      ovr_d      = ovr_q;
      irq_en_d   = irq_en_q;
      done_set_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (wr_c && (sel_c == SEL_TX)) begin
               tx_d    = pwdata;
               bdi_d   = pwdata;
               done_d  = 1'b0;
               lcnt_d  = lcnt_q + LW'(1);
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wcnt_d  = CW'(LATENCY - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wcnt_q == '0) begin
               rx_d       = buf_data_out;
               done_set_c = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Set beats clear for both sticky status bits.
      if (rd_c && (sel_c == SEL_RX)) done_d = 1'b0;
      if (done_set_c) done_d = 1'b1;
      if (wr_c && (sel_c == SEL_STATUS) && pwdata[2]) ovr_d = 1'b0;
      if (ovr_set_c) ovr_d = 1'b1;
      if (wr_c && (sel_c == SEL_CTRL)) irq_en_d = pwdata[0];

      irq_d = done_d & irq_en_d;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= ST_IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         bdi_q    <= IDLE_WORD;
         lcnt_q   <= '0;
         wcnt_q   <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         bdi_q    <= bdi_d;
         lcnt_q   <= lcnt_d;
         wcnt_q   <= wcnt_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

endmodule

// File: tb/tb_apb_buf_port.sv
// Scoreboard bench for apb_buf_port against a delay-line model of the downstream buffer.
module tb_apb_buf_port;

   localparam int unsigned LAT = 2;
   localparam logic [31:0] IDLE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [3:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [31:0] buf_data_in, buf_data_out;
   logic        irq;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [31:0] exp_buf_q[$];
   logic [31:0] exp_rx_q[$];
   logic [7:0]  exp_lcnt = '0;

   always #5 clk = ~clk;

   apb_buf_port #(.LATENCY(LAT), .IDLE_WORD(IDLE)) dut (
      .clk(clk), .rst_l(rst_l), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .buf_data_in(buf_data_in), .buf_data_out(buf_data_out),
      .irq(irq)
   );

   // Downstream buffer model: word sampled at an edge appears LAT edges later.
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= buf_data_in;
   end
   assign buf_data_out = pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Every non-idle word on buf_data_in must be an expected launch, one cycle each.
   always @(negedge clk) begin
      if (rst_l && buf_data_in !== IDLE) begin
         if (exp_buf_q.size() == 0) chk("buf_extra", buf_data_in, IDLE);
         else chk("buf_launch", buf_data_in, exp_buf_q.pop_front());
      end
   end

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
      psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk); err = pslverr;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
      psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk); d = prdata;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic launch(input logic [31:0] d);
      logic e;
      exp_buf_q.push_back(d);
      exp_rx_q.push_back(d);
      exp_lcnt++;
      apb_write(4'h0, d, e);
   endtask

   task automatic wait_done();
      logic [31:0] s;
      int k;
      s = '0;
      for (k = 0; k < 20; k++) begin
         apb_read(4'h8, s);
         if (s[1]) break;
      end
      if (!s[1]) chk("done_timeout", s, 32'h2);
   endtask

   task automatic read_rx_check(input string tag);
      logic [31:0] d;
      apb_read(4'h4, d);
      if (exp_rx_q.size() == 0) chk({tag, "_empty"}, 32'd0, 32'd1);
      else chk(tag, d, exp_rx_q.pop_front());
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          n;

      // Reset state.
      #12;
      chk("rst_buf", buf_data_in, IDLE);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("pready", 32'(pready), 32'd1);
      @(negedge clk); rst_l = 1'b1;
      @(posedge clk); #1;
      apb_read(4'h8, d); chk("rst_status", d, 32'h0);
      apb_read(4'h4, d); chk("rst_rx", d, 32'h0);
      apb_read(4'h0, d); chk("rst_tx", d, 32'h0);
      apb_read(4'hC, d); chk("rst_ctrl", d, 32'h0);
      chk("idle_prdata", prdata, 32'h0);

      // Single launch with exact timing.
      launch(32'hA5A5_0001);
      chk("launch_buf", buf_data_in, 32'hA5A5_0001);
      apb_read(4'h8, d); chk("status_busy", d, {16'h0, exp_lcnt, 8'h01});
      apb_read(4'h8, d); chk("status_done_e3", d, {16'h0, exp_lcnt, 8'h02});
      read_rx_check("rx_single");
      apb_read(4'h8, d); chk("status_after_rx", d, {16'h0, exp_lcnt, 8'h00});

      // Overrun: second TX write while busy.
      launch(32'h1111_2222);
      apb_write(4'h0, 32'h3333_4444, e);
      chk("ovr_pslverr", 32'(e), 32'd1);
      wait_done();
      apb_read(4'h0, d); chk("ovr_tx_hold", d, 32'h1111_2222);
      apb_read(4'h8, d); chk("ovr_status", d, {16'h0, exp_lcnt, 8'h06});
      read_rx_check("rx_ovr");
      apb_write(4'h4, 32'hDEAD_BEEF, e); chk("rx_wr_err", 32'(e), 32'd0);
      apb_read(4'h4, d); chk("rx_wr_noeffect", d, 32'h1111_2222);
      apb_write(4'h8, 32'h0000_0003, e); chk("status_wr_err", 32'(e), 32'd0);
      apb_read(4'h8, d); chk("ovr_kept", d, {16'h0, exp_lcnt, 8'h04});
      apb_write(4'h8, 32'h0000_0004, e);
      apb_read(4'h8, d); chk("ovr_clr", d, {16'h0, exp_lcnt, 8'h00});

      // Interrupt.
      apb_write(4'hC, 32'hFFFF_FFFF, e);
      apb_read(4'hC, d); chk("ctrl_rb", d, 32'h1);
      launch(32'h0BAD_CAFE);
      chk("irq_low_launch", 32'(irq), 32'd0);
      n = 0;
      while (!irq && n < 20) begin @(posedge clk); #1; n++; end
      chk("irq_latency", 32'(n), 32'd3);
      read_rx_check("rx_irq");
      chk("irq_clr", 32'(irq), 32'd0);
      // RX read landing on the DONE-set edge: set wins.
      launch(32'h5A5A_7777);
      @(posedge clk); #1;
      apb_read(4'h4, d);
      chk("irq_set_wins", 32'(irq), 32'd1);
      apb_read(4'h8, d); chk("done_set_wins", d, {16'h0, exp_lcnt, 8'h02});
      read_rx_check("rx_coincide");
      apb_write(4'hC, 32'h0, e);

      // 256 launches from a fresh reset; LCNT wraps to zero.
      @(negedge clk); rst_l = 1'b0;
      exp_lcnt = '0;
      @(negedge clk); rst_l = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         launch(32'h1000_0000 + 32'(i));
         wait_done();
         read_rx_check("rx_loop");
      end
      apb_read(4'h8, d); chk("lcnt_wrap", d, 32'h0);

      // Reset in WAIT aborts the operation.
      launch(32'h7777_8888);
      @(posedge clk); @(posedge clk); #3;
      rst_l = 1'b0; #1;
      chk("abort_buf", buf_data_in, IDLE);
      chk("abort_irq", 32'(irq), 32'd0);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h8; #1;
      chk("abort_status", prdata, 32'h0);
      paddr = 4'h4; #1;
      chk("abort_rx", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
      exp_rx_q.delete();
      exp_lcnt = '0;
      @(negedge clk); rst_l = 1'b1;
      repeat (6) @(posedge clk); #1;
      apb_read(4'h8, d); chk("abort_no_done", d, 32'h0);
      apb_read(4'h4, d); chk("abort_rx_after", d, 32'h0);

      // First write after reset launches.
      launch(32'hC0DE_0042);
      wait_done();
      read_rx_check("rx_post_reset");
      chk("buf_q_drained", 32'(exp_buf_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
